// File: rtl/bitwise_logic_unit.sv
// Two-stage bitwise logic unit with valid/ready handshakes on both sides.
// An accumulator mode can replace operand B with the current result register.
module bitwise_logic_unit #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  input  logic         acc_en,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         zero,
  output logic         all_ones,
  output logic         parity
);

  logic         init_done;
  logic         vld_p1;
  logic [N-1:0] a_p1;
  logic [N-1:0] b_p1;
  logic [2:0]   op_p1;
  logic         acc_en_p1;
  logic         adv;
  logic         accept;
  logic [N-1:0] b_eff;
  logic [N-1:0] res_nxt;

  function automatic logic [N-1:0] logic_op(input logic [2:0] sel,
                                            input logic [N-1:0] x,
                                            input logic [N-1:0] y);
    logic [N-1:0] r;
    case (sel)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x & y);
      3'b100:  r = ~(x | y);
      3'b101:  r = ~(x ^ y);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // in_ready is held low until the first edge after reset release.
  assign adv      = vld_p1 && (!out_valid || out_ready);
  assign in_ready = init_done && (!vld_p1 || adv);
  assign accept   = in_valid && in_ready;

  // The result register doubles as the accumulator, so forwarding is free.
  assign b_eff    = acc_en_p1 ? result : b_p1;
  assign res_nxt  = logic_op(op_p1, a_p1, b_eff);

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (accept)
        vld_p1 <= 1'b1;
      else if (adv)
        vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1      <= a;
      b_p1      <= b;
      op_p1     <= op;
      acc_en_p1 <= acc_en;
    end
  end

  // Stage 2: compute, load result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b1;
      all_ones  <= 1'b0;
      parity    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (adv) begin
        result   <= res_nxt;
        zero     <= ~|res_nxt;
        all_ones <= &res_nxt;
        parity   <= ^res_nxt;
      end
      if (adv)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Bench for bitwise_logic_unit: directed cases at N=6, then random traffic at
// N=1, 6 and 32 scored against an in-order transaction queue model.
module tb_bitwise_logic_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a_v [3];
  logic [63:0] b_v [3];
  logic [2:0]  op_v [3];
  logic        acc_v [3];
  logic        iv_v [3];
  logic        or_v [3];
  logic        ir_v [3];
  logic        ov_v [3];
  logic        z_v [3];
  logic        ao_v [3];
  logic        p_v [3];
  logic [63:0] r_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 6 : 32);
    logic [W-1:0] res;
    bitwise_logic_unit #(.N(W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a(a_v[g][W-1:0]), .b(b_v[g][W-1:0]), .op(op_v[g]), .acc_en(acc_v[g]),
      .in_valid(iv_v[g]), .in_ready(ir_v[g]),
      .result(res), .out_valid(ov_v[g]), .out_ready(or_v[g]),
      .zero(z_v[g]), .all_ones(ao_v[g]), .parity(p_v[g])
    );
    assign r_v[g] = 64'(res);
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q [3][$];
  logic [63:0] got [$];
  logic [63:0] acc_m [3];
  logic        hold_v [3];
  logic [63:0] hold_r [3];

  logic        acc_fl, pop_fl;
  logic        s_ov, s_ir, s_z, s_ao, s_p;
  logic [63:0] s_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int g);
    int w;
    w = (g == 0) ? 1 : ((g == 1) ? 6 : 32);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Truth-table reference, straight from the op encoding.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x,
                                         input logic [63:0] y, input logic [63:0] m);
    logic [63:0] r;
    case (o)
      3'd0:    r = x & y;
      3'd1:    r = x | y;
      3'd2:    r = x ^ y;
      3'd3:    r = ~(x & y);
      3'd4:    r = ~(x | y);
      3'd5:    r = ~(x ^ y);
      3'd6:    r = ~x;
      default: r = x;
    endcase
    return r & m;
  endfunction

  task automatic clear_model();
    for (int g = 0; g < 3; g++) begin
      q[g].delete();
      acc_m[g]  = 64'd0;
      hold_v[g] = 1'b0;
      iv_v[g]   = 1'b0;
      or_v[g]   = 1'b0;
    end
  endtask

  // Called at posedge+1 with inputs already driven; samples at the negedge,
  // updates the scoreboard, and returns at the following posedge+1.
  task automatic step(input int g);
    logic [63:0] e, m;
    m = mask_of(g);
    @(negedge clk);
    s_ov = ov_v[g]; s_ir = ir_v[g]; s_res = r_v[g];
    s_z = z_v[g]; s_ao = ao_v[g]; s_p = p_v[g];
    acc_fl = iv_v[g] && ir_v[g];
    pop_fl = ov_v[g] && or_v[g];
    if (hold_v[g]) begin
      chk("hold_valid", 64'(ov_v[g]), 64'd1);
      chk("hold_result", r_v[g], hold_r[g]);
    end
    hold_v[g] = ov_v[g] && !or_v[g];
    hold_r[g] = r_v[g];
    if (pop_fl) begin
      if (q[g].size() == 0) begin
        chk("spurious_out", 64'(q[g].size()), 64'd1);
      end else begin
        e = q[g].pop_front();
        got.push_back(r_v[g]);
        chk("sb_result", r_v[g], e);
        chk("sb_zero", 64'(z_v[g]), 64'(e == 64'd0));
        chk("sb_all_ones", 64'(ao_v[g]), 64'(e == m));
        chk("sb_parity", 64'(p_v[g]), 64'($countones(e) & 1));
      end
    end
    if (acc_fl) begin
      e = ref_op(op_v[g], a_v[g] & m, acc_v[g] ? acc_m[g] : (b_v[g] & m), m);
      q[g].push_back(e);
      acc_m[g] = e;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int g, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] o, input logic acc);
    iv_v[g] = 1'b1; a_v[g] = a; b_v[g] = b; op_v[g] = o; acc_v[g] = acc;
  endtask

  // Issue one op at N=6 with out_ready high and check the 2-cycle latency.
  task automatic one_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] o, input logic [63:0] exp);
    or_v[1] = 1'b1;
    drive(1, a, b, o, 1'b0);
    step(1);
    chk({tag, "_accept"}, 64'(acc_fl), 64'd1);
    iv_v[1] = 1'b0;
    step(1);
    chk({tag, "_early"}, 64'(s_ov), 64'd0);
    step(1);
    chk({tag, "_valid"}, 64'(s_ov), 64'd1);
    chk({tag, "_result"}, s_res, exp);
  endtask

  logic [63:0] bp_a [3];
  logic [63:0] bp_b [3];
  logic [2:0]  bp_o [3];
  logic [63:0] bp_e [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int sent;
    for (int g = 0; g < 3; g++) begin
      a_v[g] = '0; b_v[g] = '0; op_v[g] = '0; acc_v[g] = 1'b0;
    end
    clear_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_result", r_v[g], 64'd0);
      chk("rst_zero", 64'(z_v[g]), 64'd1);
      chk("rst_all_ones", 64'(ao_v[g]), 64'd0);
      chk("rst_parity", 64'(p_v[g]), 64'd0);
      chk("rst_out_valid", 64'(ov_v[g]), 64'd0);
      chk("rst_in_ready", 64'(ir_v[g]), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 64'(ir_v[1]), 64'd0);
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) chk("rdy_after_edge", 64'(ir_v[g]), 64'd1);

    one_op("and", 64'b001110, 64'b010100, 3'b000, 64'b000100);
    one_op("or",  64'b001110, 64'b010100, 3'b001, 64'b011110);
    one_op("nor", 64'b001110, 64'b010100, 3'b100, 64'b100001);
    one_op("xor", 64'b111111, 64'b101010, 3'b010, 64'b010101);
    chk("xor_zero", 64'(s_z), 64'd0);
    chk("xor_all_ones", 64'(s_ao), 64'd0);
    chk("xor_parity", 64'(s_p), 64'd1);
    one_op("pass", 64'b111111, 64'b000000, 3'b111, 64'b111111);
    chk("pass_all_ones", 64'(s_ao), 64'd1);
    chk("pass_zero", 64'(s_z), 64'd0);
    step(1);

    // Backpressure: three inputs against a stalled output.
    bp_a = '{64'b111000, 64'b000001, 64'b110011};
    bp_b = '{64'b101101, 64'b000010, 64'b000000};
    bp_o = '{3'b000, 3'b001, 3'b110};
    bp_e = '{64'b101000, 64'b000011, 64'b001100};
    got.delete();
    sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (sent < 3) drive(1, bp_a[sent], bp_b[sent], bp_o[sent], 1'b0);
      else iv_v[1] = 1'b0;
      or_v[1] = (cyc >= 4);
      step(1);
      if (cyc == 2 || cyc == 3) begin
        chk("bp_in_ready", 64'(s_ir), 64'd0);
        chk("bp_out_valid", 64'(s_ov), 64'd1);
        chk("bp_hold_first", s_res, bp_e[0]);
      end
      if (acc_fl) sent++;
    end
    chk("bp_sent", 64'(sent), 64'd3);
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk("bp_order", got[i], bp_e[i]);
    end

    // Accumulate with back-to-back forwarding.
    or_v[1] = 1'b1;
    drive(1, 64'b000011, 64'b000000, 3'b001, 1'b0);
    step(1);
    chk("fw_accept0", 64'(acc_fl), 64'd1);
    drive(1, 64'b000101, 64'b111111, 3'b010, 1'b1);
    step(1);
    chk("fw_accept1", 64'(acc_fl), 64'd1);
    iv_v[1] = 1'b0;
    step(1);
    chk("fw_first_valid", 64'(s_ov), 64'd1);
    chk("fw_first", s_res, 64'b000011);
    step(1);
    chk("fw_second_valid", 64'(s_ov), 64'd1);
    chk("fw_second", s_res, 64'b000110);
    step(1);

    // Reset one cycle after accepting a transaction.
    drive(1, 64'b111111, 64'b111111, 3'b000, 1'b0);
    step(1);
    chk("mr_accept", 64'(acc_fl), 64'd1);
    iv_v[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_result", r_v[1], 64'd0);
    chk("mr_zero", 64'(z_v[1]), 64'd1);
    chk("mr_out_valid", 64'(ov_v[1]), 64'd0);
    chk("mr_in_ready", 64'(ir_v[1]), 64'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("mr_no_output", 64'(s_ov), 64'd0);
      chk("mr_rdy_rise", 64'(s_ir), (i == 0) ? 64'd0 : 64'd1);
    end

    // Random traffic per width.
    for (int g = 0; g < 3; g++) begin
      iv_v[g] = 1'b0;
      acc_fl = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        if (!iv_v[g] || acc_fl) begin
          iv_v[g]  = ($urandom_range(3) != 0);
          a_v[g]   = {$urandom, $urandom};
          b_v[g]   = {$urandom, $urandom};
          op_v[g]  = 3'($urandom_range(7));
          acc_v[g] = 1'($urandom_range(1));
        end
        or_v[g] = ($urandom_range(2) != 0);
        step(g);
      end
      iv_v[g] = 1'b0;
      or_v[g] = 1'b1;
      for (int k = 0; k < 10 && q[g].size() != 0; k++) step(g);
      chk("rnd_drain", 64'(q[g].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
